// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: core fetch, program loader and IMEM array signals of the instruction memory arbiter
interface imem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              boot_done;
  logic              core_hold;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [DATA_W-1:0] fetch_rdata;
  logic              fetch_err;
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;
  modport slave (
    input  boot_done, fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rd,
    output core_hold, fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
           ld_gnt, ld_rvalid, ld_rdata, ld_err, mem_addr, mem_we, mem_wd
  );
  modport master (
    output boot_done, fetch_req, fetch_addr, ld_req, ld_we, ld_addr, ld_wdata, mem_rd,
    input  core_hold, fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err,
           ld_gnt, ld_rvalid, ld_rdata, ld_err, mem_addr, mem_we, mem_wd
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port IMEM between core fetch and program loader, boot hold plus starvation-bounded loader priority
module imem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 128,
  parameter int STARVE_LIM  = 4
) (
  input logic           clk,
  input logic           reset,
  imem_arbiter_if.slave bus
);
  typedef enum logic {BOOT, RUN} state_t;
  localparam int CW = $clog2(STARVE_LIM + 1);
  state_t          state, state_nx;
  logic [CW-1:0]   starve_cnt;
  logic            starve, f_ok, l_ok;
  function automatic logic legal(input logic [ADDR_W-1:0] a);
    return a[1:0] == 2'b00 && (a >> 2) < ADDR_W'(DEPTH_WORDS);
  endfunction
  always_ff @(posedge clk)
    state <= reset ? BOOT : state_nx;
  always_comb
    state_nx = (state == BOOT && bus.boot_done) ? RUN : state;
  always_comb begin
    bus.core_hold = state == BOOT;
    starve        = bus.fetch_req && starve_cnt == CW'(STARVE_LIM);
    bus.ld_gnt    = !reset && bus.ld_req && !(state == RUN && starve);
    bus.fetch_gnt = !reset && state == RUN && bus.fetch_req && (!bus.ld_req || starve);
    bus.mem_addr  = bus.ld_gnt ? bus.ld_addr : bus.fetch_gnt ? bus.fetch_addr : '0;
    l_ok          = legal(bus.ld_addr);
    f_ok          = legal(bus.fetch_addr);
    bus.mem_we    = bus.ld_gnt && bus.ld_we && l_ok;
    bus.mem_wd    = bus.ld_gnt ? bus.ld_wdata : '0;
  end
  // Responses capture mem_rd at the grant edge; illegal accesses return zero data with err.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.fetch_rvalid <= 1'b0;
      bus.fetch_rdata  <= '0;
      bus.fetch_err    <= 1'b0;
      bus.ld_rvalid    <= 1'b0;
      bus.ld_rdata     <= '0;
      bus.ld_err       <= 1'b0;
    end else begin
      bus.fetch_rvalid <= bus.fetch_gnt;
      bus.fetch_rdata  <= (bus.fetch_gnt && f_ok) ? bus.mem_rd : '0;
      bus.fetch_err    <= bus.fetch_gnt && !f_ok;
      bus.ld_rvalid    <= bus.ld_gnt;
      bus.ld_rdata     <= (bus.ld_gnt && !bus.ld_we && l_ok) ? bus.mem_rd : '0;
      bus.ld_err       <= bus.ld_gnt && !l_ok;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || !bus.fetch_req || bus.fetch_gnt)
      starve_cnt <= '0;
    else if (state == RUN && bus.ld_gnt)
      starve_cnt <= starve_cnt + CW'(1);
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed checks of boot hold, load/run, starvation bound, errors, readback and reset
module tb_imem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mem [0:127];
  imem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(128), .STARVE_LIM(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.mem_rd = mem[bus.mem_addr[8:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[8:2]] <= bus.mem_wd;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ld_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_we, input logic [31:0] exp_rd, input logic exp_err);
    bus.ld_req = 1'b1; bus.ld_we = we; bus.ld_addr = addr; bus.ld_wdata = wd;
    #1;
    check("ld_gnt", 32'(bus.ld_gnt), 32'd1);
    check("mem_we", 32'(bus.mem_we), 32'(exp_we));
    tick();
    bus.ld_req = 1'b0;
    check("ld_rvalid", 32'(bus.ld_rvalid), 32'd1);
    check("ld_rdata", bus.ld_rdata, exp_rd);
    check("ld_err", 32'(bus.ld_err), 32'(exp_err));
  endtask
  task automatic f_op(input logic [31:0] addr, input logic [31:0] exp_rd, input logic exp_err);
    bus.fetch_req = 1'b1; bus.fetch_addr = addr;
    #1;
    check("fetch_gnt", 32'(bus.fetch_gnt), 32'd1);
    tick();
    bus.fetch_req = 1'b0;
    check("fetch_rvalid", 32'(bus.fetch_rvalid), 32'd1);
    check("fetch_rdata", bus.fetch_rdata, exp_rd);
    check("fetch_err", 32'(bus.fetch_err), 32'(exp_err));
  endtask
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    reset = 1'b1;
    bus.boot_done = 1'b0; bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = '0; bus.ld_wdata = 32'hFFFF_FFFF;
    tick(); tick();
    check("rst_core_hold", 32'(bus.core_hold), 32'd1);
    check("rst_ld_gnt", 32'(bus.ld_gnt), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_ld_rvalid", 32'(bus.ld_rvalid), 32'd0);
    check("rst_fetch_rvalid", 32'(bus.fetch_rvalid), 32'd0);
    check("rst_ld_rdata", bus.ld_rdata, 32'h0);
    bus.ld_req = 1'b0;
    reset = 1'b0;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h8;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("boot_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
      check("boot_core_hold", 32'(bus.core_hold), 32'd1);
      @(posedge clk);
    end
    #1;
    bus.fetch_req = 1'b0;
    check("boot_fetch_rvalid", 32'(bus.fetch_rvalid), 32'd0);
    ld_op(1'b1, 32'h0, 32'h0000_0493, 1'b1, 32'h0, 1'b0);
    ld_op(1'b1, 32'h8, 32'h00A0_0293, 1'b1, 32'h0, 1'b0);
    bus.boot_done = 1'b1;
    check("pre_run_core_hold", 32'(bus.core_hold), 32'd1);
    ld_op(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
    bus.boot_done = 1'b0;
    check("run_core_hold", 32'(bus.core_hold), 32'd0);
    tick();
    check("ld_rvalid_pulse", 32'(bus.ld_rvalid), 32'd0);
    f_op(32'h8, 32'h00A0_0293, 1'b0);
    f_op(32'h10, 32'hDEAD_BEEF, 1'b0);
    f_op(32'h6, 32'h0, 1'b1);
    f_op(32'h200, 32'h0, 1'b1);
    ld_op(1'b1, 32'h200, 32'h0000_0BAD, 1'b0, 32'h0, 1'b1);
    ld_op(1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_0493, 1'b0);
    f_op(32'h0, 32'h0000_0493, 1'b0);
    ld_op(1'b1, 32'h20, 32'h1234_5678, 1'b1, 32'h0, 1'b0);
    f_op(32'h20, 32'h1234_5678, 1'b0);
    tick();
    check("fetch_rvalid_pulse", 32'(bus.fetch_rvalid), 32'd0);
    bus.boot_done = 1'b1;
    tick();
    bus.boot_done = 1'b0;
    check("run_ignores_boot_done", 32'(bus.core_hold), 32'd0);
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h0;
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h8;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("starve_ld_gnt", 32'(bus.ld_gnt), 32'((i % 5) != 4));
      check("starve_fetch_gnt", 32'(bus.fetch_gnt), 32'((i % 5) == 4));
      @(posedge clk);
    end
    #1;
    bus.ld_req = 1'b0;
    tick();
    #1;
    check("reset_fetch_gnt_pre", 32'(bus.fetch_gnt), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
    tick();
    reset = 1'b0;
    check("reset_no_rvalid", 32'(bus.fetch_rvalid), 32'd0);
    check("reset_core_hold", 32'(bus.core_hold), 32'd1);
    #1;
    check("reset_boot_fetch_gnt", 32'(bus.fetch_gnt), 32'd0);
    bus.fetch_req = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
